// File: rtl/cs_pkg.sv
// Shared definitions for the CS block writer: controller state encodings
// as seen on state_i, and the writer's own state type.
package cs_pkg;

    // Controller state encodings (controller state_o)
    localparam logic [2:0] CS_RST  = 3'b000;
    localparam logic [2:0] CS_INIT = 3'b001;
    localparam logic [2:0] CS_RUN  = 3'b010;
    localparam logic [2:0] CS_WR   = 3'b011;

    // Writer state
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        READY   = 2'b10,
        WRITE   = 2'b11
    } wr_state_t;

endpackage

// File: rtl/cs_sum_acc.sv
// Modular block accumulator. Sums accepted words modulo 2^DATA_W and
// presents the two's-complement checksum, so that a block plus its
// checksum word sums to zero.
module cs_sum_acc #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] chk
);

    logic [DATA_W-1:0] sum_r;

    // Accumulate accepted words; clear has priority over accumulate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_r <= '0;
        end else if (clr) begin
            sum_r <= '0;
        end else if (add_en) begin
            sum_r <= sum_r + din;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign chk = (~sum_r) + DATA_W'(1);

endmodule

// File: rtl/cs_block_writer.sv
// CS block writer: gathers BLOCK_LEN words while the controller runs,
// requests a write, then streams the block plus a checksum word to the
// memory port one word per cs_en tick.
module cs_block_writer
    import cs_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BLOCK_LEN = 4,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_rst,
    input  logic              cs_en,
    input  logic [2:0]        state_i,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              we_en,
    output logic              flag_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        blk_cnt
);

    // One counter width covers word count (0..BLOCK_LEN) and write
    // index (0..BLOCK_LEN+1, the last value meaning "checksum done").
    localparam int CNT_W = $clog2(BLOCK_LEN + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);
    localparam logic [CNT_W-1:0] CHK_IDX  = CNT_W'(BLOCK_LEN);
    localparam logic [CNT_W-1:0] DONE_IDX = CNT_W'(BLOCK_LEN + 1);

    wr_state_t         state_r;
    wr_state_t         state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  idx_r;
    logic [DATA_W-1:0] buf_r [BLOCK_LEN];

    logic              accept_s;
    logic              wr_tick_s;
    logic              finish_s;
    logic              abort_s;
    logic              clr_s;
    logic              we_en_s;
    logic              flag_cs_s;
    logic [DATA_W-1:0] chk_s;
    logic [DATA_W-1:0] buf_rd_s;
    logic [DATA_W-1:0] wdata_s;

    logic              we_en_r;
    logic              flag_cs_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [7:0]        blk_cnt_r;

    cs_sum_acc #(
        .DATA_W (DATA_W)
    ) u_sum_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_s),
        .add_en (accept_s),
        .din    (din),
        .chk    (chk_s)
    );

    // Writer state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus per-cycle control strobes; soft clear overrides all.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        wr_tick_s = 1'b0;
        finish_s  = 1'b0;
        abort_s   = 1'b0;
        if (cs_rst) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (state_i == CS_RUN) begin
                        state_s = COLLECT;
                    end else begin
                        state_s = IDLE;
                    end
                end
                COLLECT: begin
                    accept_s = cs_en && din_valid;
                    if (accept_s && (cnt_r == LAST_CNT)) begin
                        state_s = READY;
                    end else begin
                        state_s = COLLECT;
                    end
                end
                READY: begin
                    if (state_i == CS_RST) begin
                        abort_s = 1'b1;
                        state_s = IDLE;
                    end else if (state_i == CS_WR) begin
                        state_s = WRITE;
                    end else begin
                        state_s = READY;
                    end
                end
                WRITE: begin
                    if (state_i == CS_RST) begin
                        abort_s = 1'b1;
                        state_s = IDLE;
                    end else if (idx_r == DONE_IDX) begin
                        finish_s = 1'b1;
                        state_s  = COLLECT;
                    end else begin
                        wr_tick_s = cs_en;
                        state_s   = WRITE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        clr_s     = cs_rst || abort_s || finish_s;
        we_en_s   = (state_s == READY);
        flag_cs_s = (state_s == READY) || (state_s == WRITE);
    end

    // Select the word for the next write strobe: buffer entry or checksum.
    always_comb begin
        buf_rd_s = '0;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            buf_rd_s = (idx_r == CNT_W'(i)) ? buf_r[i] : buf_rd_s;
        end
        if (idx_r == CHK_IDX) begin
            wdata_s = chk_s;
        end else begin
            wdata_s = buf_rd_s;
        end
    end

    // Word counter and write index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (clr_s) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else begin
            if (accept_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (wr_tick_s) begin
                idx_r <= idx_r + CNT_W'(1);
            end
        end
    end

    // Block buffer: accepted word lands at the current count position.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BLOCK_LEN; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BLOCK_LEN; i++) begin
                if (accept_s && (cnt_r == CNT_W'(i))) begin
                    buf_r[i] <= din;
                end
            end
        end
    end

    // Registered outputs. The address advances the clk after each strobe,
    // so it shows the strobe's address during the strobe and the next
    // unwritten address otherwise, even across a soft clear or abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_en_r     <= 1'b0;
            flag_cs_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
            mem_addr_r  <= '0;
            blk_cnt_r   <= 8'd0;
        end else begin
            we_en_r   <= we_en_s;
            flag_cs_r <= flag_cs_s;
            mem_we_r  <= wr_tick_s;
            if (wr_tick_s) begin
                mem_wdata_r <= wdata_s;
            end
            if (mem_we_r) begin
                mem_addr_r <= mem_addr_r + ADDR_W'(1);
            end
            if (finish_s) begin
                blk_cnt_r <= blk_cnt_r + 8'd1;
            end
        end
    end

    assign we_en     = we_en_r;
    assign flag_cs   = flag_cs_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign blk_cnt   = blk_cnt_r;

endmodule

// File: doc/cs_block_writer.md
Name: cs_block_writer

Overview:
Downstream consumer of the CS controller. It collects BLOCK_LEN data words while the controller sits in its run state (3'b010) and, once the block is full, raises we_en. When the controller enters its write state (3'b011), it writes the block plus a two's-complement checksum word to a memory port. flag_cs stays high for the whole ready/write window, so the controller holds 3'b011 until the write completes.

Parameters:
DATA_W, 8, data and checksum word width
BLOCK_LEN, 4, data words per block (≥1)
ADDR_W, 4, memory address width; address wraps modulo 2^ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-low, clears all state
cs_rst  in  1  controller soft clear (rst_cs), active-high, synchronous to clk
cs_en  in  1  tick enable, one clk cycle per clk_4 period; replaces the gated clk_cs
state_i  in  3  controller state (state_o)
din  in  DATA_W  input data word
din_valid  in  1  din qualifier, sampled only on cs_en ticks
we_en  out  1  block full, request write (to controller we_en)
flag_cs  out  1  block pending or being written (to controller flag_cs)
mem_we  out  1  memory write strobe, one clk wide
mem_addr  out  ADDR_W  memory write address
mem_wdata  out  DATA_W  memory write data
blk_cnt  out  8  completed blocks, wraps at 255→0

Behaviour:
- Reset: rst=0 at a clk edge → IDLE. All outputs 0, including mem_addr, blk_cnt, word counter, sum and buffer.
- Priority: rst > cs_rst > everything else.
- cs_rst=1 → IDLE next edge; clears word counter, sum, we_en, flag_cs and mem_we; mem_addr and blk_cnt are kept.
- States:
  - IDLE: → COLLECT when cs_rst=0 and state_i==3'b010.
  - COLLECT:
    - On each cs_en&din_valid: buf[cnt]<=din; sum<=sum+din mod 2^DATA_W; cnt++.
    - Going from cnt=BLOCK_LEN-1 to full → READY.
    - din_valid without cs_en is ignored.
  - READY: we_en=1, flag_cs=1, further din ignored. → WRITE on the first clk with state_i==3'b011.
  - WRITE: flag_cs=1, we_en=0.
    - On each cs_en tick: mem_we=1 for that clk, mem_wdata=buf[idx], mem_addr incremented after each write.
    - After BLOCK_LEN data writes, one more tick writes chk=(~sum)+1 mod 2^DATA_W, so the block sums to 0.
    - On the clk after the chk write: flag_cs=0, blk_cnt++, cnt/sum/idx cleared → COLLECT.
- Outputs are registered. we_en and flag_cs rise on the clk after the BLOCK_LEN-th accepted word. flag_cs falls one clk after the chk strobe.
- Abort: state_i==3'b000 while in READY/WRITE → IDLE with the same clears as cs_rst. A partial block is discarded; mem_addr stays at the next unwritten address.
- mem_addr wraps 2^ADDR_W-1 → 0 silently.
- Sum overflow wraps modulo 2^DATA_W; no saturation.
- state_i values outside 000/010/011 are treated as hold (no transition).

Decomposition:
- Shared package cs_pkg:
  - controller state encodings: CS_RST=3'b000, CS_INIT=3'b001, CS_RUN=3'b010, CS_WR=3'b011
  - writer state typedef {IDLE, COLLECT, READY, WRITE}
- One natural sub-module: cs_sum_acc, holding the modular accumulator, clear, and the two's-complement checksum output.

Test Plan:
- Basic block, defaults: din 0x01,0x02,0x03,0x04 on cs_en ticks, state_i 010 then 011 after we_en → writes 01,02,03,04,F6 at addr 0..4; flag_cs high from full until 1 clk after the F6 strobe; blk_cnt=1.
- Overflow: din 0xFF×4 → sum 0xFC, chk 0x04 written at addr 4.
- Address wrap, ADDR_W=3: two blocks → second block writes at addr 5,6,7,0,1; mem_addr ends at 2.
- Enable gating: din_valid=1 with cs_en=0 for 10 clk → no words captured, we_en stays 0.
- Mid-write abort: cs_rst=1 after the 2nd write strobe → mem_we stops, flag_cs=0 next edge, mem_addr=2 retained, blk_cnt unchanged.
- Reset dominance: rst=0 together with cs_rst=1 and active writes → all outputs 0 next edge, including mem_addr and blk_cnt.
